nios2_mul_sequencer: RTL and testbench

Two-pass sequencer that sits directly upstream of the processor's 32x16 multiply cell and also consumes its result. It accepts 32x32 multiply requests from the execute stage. Each request is issued to the cell as two partial products, first src2[15:0] and then src2[31:16]. The sequencer combines the two partials into the low 32 bits of the product and returns them with a destination tag over a valid/ready handshake. The cell computes cell_result = low32(cell_src1 * cell_src2[15:0]) with a fixed pipeline latency.

---
 rtl/nios2_mul_sequencer.sv | 147 ++++++++++++++
 tb/tb_nios2_mul_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_mul_sequencer.sv
// Two-pass 32x32 multiply sequencer in front of a 32x16 multiply cell.
// Issues src2[15:0] then src2[31:16], then folds both partials into the low 32 bits of the product.
module nios2_mul_sequencer #(
  parameter int unsigned CELL_LATENCY = 1,
  parameter int unsigned TAG_W        = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_src1,
  input  logic [31:0]      req_src2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic [31:0]      cell_src1,
  output logic [31:0]      cell_src2,
  input  logic [31:0]      cell_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_LO,
    S_ISSUE_HI,
    S_WAIT,
    S_RESULT
  } state_e;

  localparam logic [2:0] LAT = 3'(CELL_LATENCY);

  state_e             state_q, state_d;
  logic [31:0]        src1_q, src1_d;
  logic [31:0]        src2_q, src2_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [31:0]        acc_q, acc_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [31:0]        res_data_q, res_data_d;
  logic [TAG_W-1:0]   res_tag_q, res_tag_d;

  // cnt counts down to the hi sample: 1 marks the lo sample, 0 the hi sample.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d    = state_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    tag_d      = tag_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    res_tag_d  = res_tag_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && !flush) begin
          src1_d  = req_src1;
          src2_d  = req_src2;
          tag_d   = req_tag;
          state_d = S_ISSUE_LO;
        end
      end
      S_ISSUE_LO: begin
        cnt_d   = LAT;
        state_d = S_ISSUE_HI;
      end
      S_ISSUE_HI: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) acc_d = cell_result;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) acc_d = cell_result;
        if (cnt_q == 3'd0) begin
          res_data_d = acc_q + {cell_result[15:0], 16'h0000};
          res_tag_d  = tag_q;
          state_d    = S_RESULT;
        end
      end
      S_RESULT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush beats every other transition; a result in flight is never published.
    if (flush && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      acc_d      = '0;
      res_data_d = res_data_q;
      res_tag_d  = res_tag_q;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; reset is synchronous and sampled here.
    if (!reset_n) begin
      state_q    <= S_IDLE;
      src1_q     <= '0;
      src2_q     <= '0;
      tag_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      res_data_q <= '0;
      res_tag_q  <= '0;
    end else begin
      state_q    <= state_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      tag_q      <= tag_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      res_data_q <= res_data_d;
      res_tag_q  <= res_tag_d;
    end
  end

  // Operands are decoded from state: hi operand holds through WAIT, zero once the hi sample is taken.
  always_comb begin
    cell_src1 = '0;
    cell_src2 = '0;
    case (state_q)
      S_ISSUE_LO: begin
        cell_src1 = src1_q;
        cell_src2 = {16'h0000, src2_q[15:0]};
      end
      S_ISSUE_HI, S_WAIT: begin
        cell_src1 = src1_q;
        cell_src2 = {16'h0000, src2_q[31:16]};
      end
      default: begin
        cell_src1 = '0;
        cell_src2 = '0;
      end
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign res_valid = (state_q == S_RESULT);
  assign res_data  = res_data_q;
  assign res_tag   = res_tag_q;

endmodule

// File: tb/tb_nios2_mul_sequencer.sv
// Directed bench for nios2_mul_sequencer: two instances (CELL_LATENCY 1 and 3), each with a pipelined cell model.
module tb_nios2_mul_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n     [2];
  logic        req_valid   [2];
  logic        req_ready   [2];
  logic [31:0] req_src1    [2];
  logic [31:0] req_src2    [2];
  logic [4:0]  req_tag     [2];
  logic        flush       [2];
  logic [31:0] cell_src1   [2];
  logic [31:0] cell_src2   [2];
  logic [31:0] cell_result [2];
  logic        res_valid   [2];
  logic        res_ready   [2];
  logic [31:0] res_data    [2];
  logic [4:0]  res_tag     [2];
  logic        busy        [2];

  for (genvar g = 0; g < 2; g++) begin : g_unit
    localparam int L = (g == 0) ? 1 : 3;
    logic [31:0] pipe [L];

    always @(posedge clk) begin
      pipe[0] <= 32'(cell_src1[g] * {16'h0000, cell_src2[g][15:0]});
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign cell_result[g] = pipe[L-1];

    nios2_mul_sequencer #(.CELL_LATENCY(L), .TAG_W(5)) u_dut (
      .clk        (clk),
      .reset_n    (reset_n[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_src1   (req_src1[g]),
      .req_src2   (req_src2[g]),
      .req_tag    (req_tag[g]),
      .flush      (flush[g]),
      .cell_src1  (cell_src1[g]),
      .cell_src2  (cell_src2[g]),
      .cell_result(cell_result[g]),
      .res_valid  (res_valid[g]),
      .res_ready  (res_ready[g]),
      .res_data   (res_data[g]),
      .res_tag    (res_tag[g]),
      .busy       (busy[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic string nm(input int u, input string s);
    return $sformatf("u%0d_%s", u, s);
  endfunction

  // Presents one request, takes the accepting edge, then drops req_valid.
  task automatic accept(input int u, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t, input string s);
    req_valid[u] = 1'b1;
    req_src1[u]  = a;
    req_src2[u]  = b;
    req_tag[u]   = t;
    check(nm(u, {s, "_req_ready"}), 32'(req_ready[u]), 32'd1);
    step();
    req_valid[u] = 1'b0;
    check(nm(u, {s, "_busy"}), 32'(busy[u]), 32'd1);
  endtask

  // Called just after the accepting edge; counts edges until res_valid, bounded.
  task automatic wait_valid(input int u, input int lat, input string s);
    int n = 0;
    while (!res_valid[u] && n < 20) begin
      step();
      n++;
    end
    check(nm(u, {s, "_latency"}), 32'(n), 32'(lat + 2));
  endtask

  task automatic check_idle_outputs(input int u, input string s, input logic [31:0] exp_data,
                                    input logic [4:0] exp_tag);
    check(nm(u, {s, "_res_valid"}), 32'(res_valid[u]), 32'd0);
    check(nm(u, {s, "_req_ready"}), 32'(req_ready[u]), 32'd1);
    check(nm(u, {s, "_busy"}),      32'(busy[u]),      32'd0);
    check(nm(u, {s, "_cell_src1"}), cell_src1[u],      32'd0);
    check(nm(u, {s, "_cell_src2"}), cell_src2[u],      32'd0);
    check(nm(u, {s, "_res_data"}),  res_data[u],       exp_data);
    check(nm(u, {s, "_res_tag"}),   32'(res_tag[u]),   32'(exp_tag));
  endtask

  task automatic run_unit(input int u);
    int lat  = (u == 0) ? 1 : 3;
    int seen;

    // Basic 3x5 with consumer always ready: exact latency and a one-cycle pulse.
    res_ready[u] = 1'b1;
    accept(u, 32'd3, 32'd5, 5'd7, "s1");
    wait_valid(u, lat, "s1");
    check(nm(u, "s1_data"), res_data[u], 32'h0000000F);
    check(nm(u, "s1_tag"),  32'(res_tag[u]), 32'd7);
    step();
    check(nm(u, "s1_pulse"), 32'(res_valid[u]), 32'd0);
    check(nm(u, "s1_ready_after"), 32'(req_ready[u]), 32'd1);

    // All-ones operands and a hi-only multiplier.
    accept(u, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, "s2a");
    wait_valid(u, lat, "s2a");
    check(nm(u, "s2a_data"), res_data[u], 32'h00000001);
    step();
    accept(u, 32'h12345678, 32'h00010000, 5'd2, "s2b");
    wait_valid(u, lat, "s2b");
    check(nm(u, "s2b_data"), res_data[u], 32'h56780000);
    step();

    // Wrapping product with the consumer stalled for five cycles.
    res_ready[u] = 1'b0;
    accept(u, 32'h80000000, 32'd2, 5'd5, "s3");
    wait_valid(u, lat, "s3");
    for (int i = 0; i < 5; i++) begin
      check(nm(u, "s3_hold_valid"), 32'(res_valid[u]), 32'd1);
      check(nm(u, "s3_hold_data"),  res_data[u], 32'h00000000);
      check(nm(u, "s3_hold_tag"),   32'(res_tag[u]), 32'd5);
      check(nm(u, "s3_hold_ready"), 32'(req_ready[u]), 32'd0);
      step();
    end
    res_ready[u] = 1'b1;
    step();
    check(nm(u, "s3_release_valid"), 32'(res_valid[u]), 32'd0);
    check(nm(u, "s3_release_busy"),  32'(busy[u]), 32'd0);

    // Back-to-back with req_valid held: second accepted right after the first handshake.
    req_valid[u] = 1'b1;
    req_src1[u]  = 32'd2;
    req_src2[u]  = 32'd3;
    req_tag[u]   = 5'd1;
    step();
    req_src1[u]  = 32'd4;
    req_src2[u]  = 32'd5;
    req_tag[u]   = 5'd2;
    wait_valid(u, lat, "s4a");
    check(nm(u, "s4a_data"), res_data[u], 32'd6);
    check(nm(u, "s4a_tag"),  32'(res_tag[u]), 32'd1);
    step();
    check(nm(u, "s4_gap_ready"), 32'(req_ready[u]), 32'd1);
    check(nm(u, "s4_gap_valid"), 32'(res_valid[u]), 32'd0);
    step();
    req_valid[u] = 1'b0;
    check(nm(u, "s4b_busy"), 32'(busy[u]), 32'd1);
    wait_valid(u, lat, "s4b");
    check(nm(u, "s4b_data"), res_data[u], 32'd20);
    check(nm(u, "s4b_tag"),  32'(res_tag[u]), 32'd2);
    step();

    // Flush during ISSUE_HI kills the request; operands visible in both issue cycles.
    accept(u, 32'd11, 32'h00030005, 5'd4, "s5");
    check(nm(u, "s5_lo_src1"), cell_src1[u], 32'd11);
    check(nm(u, "s5_lo_src2"), cell_src2[u], 32'd5);
    step();
    check(nm(u, "s5_hi_src1"), cell_src1[u], 32'd11);
    check(nm(u, "s5_hi_src2"), cell_src2[u], 32'd3);
    flush[u] = 1'b1;
    step();
    flush[u] = 1'b0;
    check_idle_outputs(u, "s5_flush", 32'd20, 5'd2);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (res_valid[u]) seen++;
      step();
    end
    check(nm(u, "s5_no_result"), 32'(seen), 32'd0);
    accept(u, 32'd7, 32'd9, 5'd6, "s5b");
    wait_valid(u, lat, "s5b");
    check(nm(u, "s5b_data"), res_data[u], 32'd63);
    check(nm(u, "s5b_tag"),  32'(res_tag[u]), 32'd6);
    step();

    // Flush in IDLE blocks acceptance that cycle.
    flush[u]     = 1'b1;
    req_valid[u] = 1'b1;
    req_src1[u]  = 32'd1;
    req_src2[u]  = 32'd1;
    step();
    flush[u]     = 1'b0;
    req_valid[u] = 1'b0;
    check(nm(u, "idle_flush_busy"), 32'(busy[u]), 32'd0);

    // One-cycle reset during WAIT clears the held result as well.
    accept(u, 32'd5, 32'd6, 5'd9, "s6");
    step();
    step();
    check(nm(u, "s6_wait_busy"), 32'(busy[u]), 32'd1);
    reset_n[u] = 1'b0;
    step();
    reset_n[u] = 1'b1;
    check_idle_outputs(u, "s6_reset", 32'd0, 5'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (res_valid[u]) seen++;
      step();
    end
    check(nm(u, "s6_no_result"), 32'(seen), 32'd0);

    // Flush in RESULT drops the unconsumed result.
    res_ready[u] = 1'b0;
    accept(u, 32'd2, 32'd21, 5'd3, "s7");
    wait_valid(u, lat, "s7");
    check(nm(u, "s7_data"), res_data[u], 32'd42);
    flush[u] = 1'b1;
    step();
    flush[u] = 1'b0;
    check(nm(u, "s7_valid"), 32'(res_valid[u]), 32'd0);
    check(nm(u, "s7_busy"),  32'(busy[u]), 32'd0);
    res_ready[u] = 1'b1;
    step();
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      reset_n[u]   = 1'b0;
      req_valid[u] = 1'b0;
      req_src1[u]  = '0;
      req_src2[u]  = '0;
      req_tag[u]   = '0;
      flush[u]     = 1'b0;
      res_ready[u] = 1'b0;
    end
    step();
    step();
    for (int u = 0; u < 2; u++) check_idle_outputs(u, "reset", 32'd0, 5'd0);
    for (int u = 0; u < 2; u++) reset_n[u] = 1'b1;
    step();
    for (int u = 0; u < 2; u++) check_idle_outputs(u, "post_reset", 32'd0, 5'd0);

    run_unit(0);
    run_unit(1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
